// File: rtl/tart_corr_pkg.sv
// Shared types and defaults for the TART correlator readout path.
package tart_corr_pkg;

  localparam int unsigned ACCUM_DEF  = 32;
  localparam int unsigned ABITS_DEF  = 7;
  localparam int unsigned WORDS_DEF  = 128;
  localparam int unsigned SETTLE_DEF = 4;

  localparam int unsigned BS_W   = 5;
  localparam int unsigned BS_MAX = 24;
  localparam int unsigned SCNT_W = 24;
  localparam int unsigned MASK_W = SCNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_READ   = 2'd2,
    ST_PUSH   = 2'd3
  } rd_state_e;

  // Terminal sample count for a block: 2^min(bs,24) - 1.
  function automatic logic [SCNT_W-1:0] block_mask(input logic [BS_W-1:0] bs);
    logic [BS_W-1:0] eff;
    eff = (bs > BS_W'(BS_MAX)) ? BS_W'(BS_MAX) : bs;
    return SCNT_W'((MASK_W'(1) << eff) - MASK_W'(1));
  endfunction

endpackage

// File: rtl/vis_block_timer.sv
// Counts antenna strobes and emits a one-cycle bank-switch pulse per block.
module vis_block_timer
  import tart_corr_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            enable_i,
  input  logic [BS_W-1:0] blocksize_i,
  input  logic            strobe_i,
  output logic            sw_o
);

  logic [SCNT_W-1:0] cnt_q;
  logic [SCNT_W-1:0] mask_c;
  logic              hit_c;

  always_comb begin
    mask_c = block_mask(blocksize_i);
    hit_c  = enable_i && strobe_i && (cnt_q == mask_c);
  end

  // Disabled means the partial block is discarded, so the next run starts fresh.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sw_o  <= 1'b0;
    end else begin
      sw_o <= hit_c;
      if (!enable_i || hit_c) begin
        cnt_q <= '0;
      end else if (strobe_i) begin
        cnt_q <= cnt_q + SCNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vis_readout_ctrl.sv
// Visibility readout: on each bank switch, reads WORDS words over the bus
// and forwards them one at a time on a ready/valid stream.
module vis_readout_ctrl
  import tart_corr_pkg::*;
#(
  parameter int unsigned ACCUM  = ACCUM_DEF,
  parameter int unsigned ABITS  = ABITS_DEF,
  parameter int unsigned WORDS  = WORDS_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [BS_W-1:0]  blocksize_i,
  input  logic             strobe_i,
  output logic             sw_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic             bst_o,
  output logic [ABITS-1:0] adr_o,
  input  logic             ack_i,
  input  logic [ACCUM-1:0] dat_i,
  output logic [ACCUM-1:0] m_dat_o,
  output logic             m_vld_o,
  input  logic             m_rdy_i,
  output logic             m_last_o,
  output logic             overrun_o
);

  localparam logic [ABITS-1:0] LAST_ADR = ABITS'(WORDS - 1);
  localparam int unsigned      SC_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SETTLE - 1);

  logic [1:0]       rst_sync_q;
  logic             rst_int_n;
  rd_state_e        state_q, state_d;
  logic [SC_W-1:0]  settle_q, settle_d;
  logic [ABITS-1:0] adr_d;
  logic             capture_c;
  logic             overrun_d;
  logic             cyc_d, bst_d, vld_d, last_d;
  logic [ACCUM-1:0] dat_d;

  assign we_o = 1'b0;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  vis_block_timer u_timer (
    .clk_i       (clk_i),
    .rst_n       (rst_int_n),
    .enable_i    (enable_i),
    .blocksize_i (blocksize_i),
    .strobe_i    (strobe_i),
    .sw_o        (sw_o)
  );

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      adr_o     <= '0;
      overrun_o <= 1'b0;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      bst_o     <= 1'b0;
      m_vld_o   <= 1'b0;
      m_last_o  <= 1'b0;
      m_dat_o   <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      adr_o     <= adr_d;
      overrun_o <= overrun_d;
      cyc_o     <= cyc_d;
      stb_o     <= cyc_d;
      bst_o     <= bst_d;
      m_vld_o   <= vld_d;
      m_last_o  <= last_d;
      m_dat_o   <= dat_d;
    end
  end

  // Next state; a switch always restarts the settle wait, aborting any readout.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    adr_d     = adr_o;
    capture_c = 1'b0;
    overrun_d = overrun_o || (sw_o && (state_q != ST_IDLE));
    if (sw_o) begin
      state_d  = ST_SETTLE;
      settle_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_SETTLE: begin
          if (settle_q == SC_LAST) begin
            state_d = ST_READ;
            adr_d   = '0;
          end else begin
            settle_d = settle_q + SC_W'(1);
          end
        end
        ST_READ: begin
          if (ack_i) begin
            state_d   = ST_PUSH;
            capture_c = 1'b1;
          end
        end
        ST_PUSH: begin
          if (m_vld_o && m_rdy_i) begin
            if (adr_o == LAST_ADR) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_READ;
              adr_d   = adr_o + ABITS'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    cyc_d  = (state_d == ST_READ);
    bst_d  = cyc_d && (adr_d != LAST_ADR);
    vld_d  = (state_d == ST_PUSH);
    last_d = vld_d && (adr_d == LAST_ADR);
    dat_d  = capture_c ? dat_i : m_dat_o;
  end

endmodule

// File: tb/tb_vis_readout_ctrl.sv
// Bench for vis_readout_ctrl: bus slave model feeds a scoreboard queue that
// is checked against the visibility stream.
module tb_vis_readout_ctrl;

  localparam int unsigned ACCUM  = 32;
  localparam int unsigned ABITS  = 7;
  localparam int unsigned WORDS  = 128;
  localparam int unsigned SETTLE = 4;

  logic             clk_i = 1'b0;
  logic             rst_n = 1'b1;
  logic             enable_i = 1'b0;
  logic [4:0]       blocksize_i = '0;
  logic             strobe_i = 1'b0;
  logic             sw_o, cyc_o, stb_o, we_o, bst_o;
  logic [ABITS-1:0] adr_o;
  logic             ack_i = 1'b0;
  logic [ACCUM-1:0] dat_i = '0;
  logic [ACCUM-1:0] m_dat_o;
  logic             m_vld_o;
  logic             m_rdy_i = 1'b1;
  logic             m_last_o, overrun_o;

  int checks = 0;
  int errors = 0;
  logic [ACCUM-1:0] exp_q[$];
  bit ack_wait = 0;

  vis_readout_ctrl #(
    .ACCUM(ACCUM), .ABITS(ABITS), .WORDS(WORDS), .SETTLE(SETTLE)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .enable_i(enable_i), .blocksize_i(blocksize_i),
    .strobe_i(strobe_i), .sw_o(sw_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .bst_o(bst_o), .adr_o(adr_o), .ack_i(ack_i), .dat_i(dat_i), .m_dat_o(m_dat_o),
    .m_vld_o(m_vld_o), .m_rdy_i(m_rdy_i), .m_last_o(m_last_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Bus slave: acknowledges one cycle after it first sees a strobe.
  always @(negedge clk_i) begin
    if (ack_i) begin
      ack_i = 1'b0;
    end else if (cyc_o && stb_o) begin
      if (ack_wait) begin
        dat_i = $urandom;
        ack_i = 1'b1;
        exp_q.push_back(dat_i);
        ack_wait = 0;
      end else begin
        ack_wait = 1;
      end
    end else begin
      ack_wait = 0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; enable_i = 1'b0; strobe_i = 1'b0; m_rdy_i = 1'b1; blocksize_i = '0;
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_i);
    exp_q.delete();
  endtask

  // One strobe with blocksize 0 gives exactly one switch; leaves the bench at the sw_o cycle.
  task automatic fire_switch();
    @(negedge clk_i);
    blocksize_i = '0; enable_i = 1'b1; strobe_i = 1'b1;
    @(negedge clk_i);
    strobe_i = 1'b0; enable_i = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({sw_o, cyc_o, stb_o, we_o, bst_o, m_vld_o, m_last_o, overrun_o} !== 8'h00 ||
        adr_o !== '0 || m_dat_o !== '0)
      $display("FAIL reset_outputs: got ctl=%b adr=%0h dat=%0h, expected all zero",
               {sw_o, cyc_o, stb_o, we_o, bst_o, m_vld_o, m_last_o, overrun_o}, adr_o, m_dat_o);
    if ({sw_o, cyc_o, stb_o, we_o, bst_o, m_vld_o, m_last_o, overrun_o} !== 8'h00 ||
        adr_o !== '0 || m_dat_o !== '0) errors++;
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_i);
    checks++;
    if (cyc_o !== 1'b0 || sw_o !== 1'b0 || m_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got cyc=%b sw=%b vld=%b, expected 0 0 0", cyc_o, sw_o, m_vld_o);
    end
  endtask

  task automatic test_block_timer();
    int ph_bs[8];
    int ph_en[8];
    int ph_st[8];
    int ph_n[8];
    int cnt_m;
    int mask;
    int pulses_a;
    logic exp_sw;
    ph_bs = '{2, 2, 2, 31, 31, 3, 3, 3};
    ph_en = '{1, 1, 0, 1, 0, 1, 0, 1};
    ph_st = '{1, 2, 1, 1, 0, 1, 1, 1};
    ph_n  = '{24, 24, 2, 100, 2, 5, 3, 20};
    do_reset();
    cnt_m = 0;
    pulses_a = 0;
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < ph_n[p]; c++) begin
        blocksize_i = 5'(ph_bs[p]);
        enable_i    = (ph_en[p] != 0);
        strobe_i    = (ph_st[p] == 2) ? 1'($urandom_range(0, 1)) : (ph_st[p] != 0);
        mask   = (1 << ((ph_bs[p] > 24) ? 24 : ph_bs[p])) - 1;
        exp_sw = enable_i && strobe_i && (cnt_m == mask);
        if (!enable_i || exp_sw) cnt_m = 0;
        else if (strobe_i) cnt_m++;
        @(negedge clk_i);
        checks++;
        if (sw_o !== exp_sw) begin
          errors++;
          $display("FAIL timer_sw phase %0d cycle %0d: got %b expected %b", p, c, sw_o, exp_sw);
        end
        if (p == 0 && sw_o === 1'b1) pulses_a++;
      end
    end
    checks++;
    if (pulses_a != 6) begin
      errors++;
      $display("FAIL timer_period: got %0d pulses in 24 cycles, expected 6", pulses_a);
    end
    do_reset();
  endtask

  task automatic test_readout(input bit rnd);
    int n;
    int count;
    bit stalled;
    logic [ACCUM-1:0] held_dat;
    logic held_last;
    logic [ACCUM-1:0] exp_dat;
    do_reset();
    fire_switch();
    checks++;
    if (sw_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_switch: got sw=%b expected 1", sw_o);
    end
    n = 0;
    while (stb_o !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n != SETTLE + 1) begin
      errors++;
      $display("FAIL rd_settle: first stb after %0d cycles, expected %0d", n, SETTLE + 1);
    end
    count = 0;
    stalled = 0;
    for (int k = 0; k < 4000 && count < WORDS; k++) begin
      if (stalled) begin
        checks++;
        if (m_vld_o !== 1'b1 || m_dat_o !== held_dat || m_last_o !== held_last) begin
          errors++;
          $display("FAIL rd_stall_stable: got vld=%b dat=%0h last=%b expected 1 %0h %b",
                   m_vld_o, m_dat_o, m_last_o, held_dat, held_last);
        end
      end
      checks++;
      if ((stb_o && m_vld_o) || (cyc_o !== stb_o) || (m_last_o && !m_vld_o)) begin
        errors++;
        $display("FAIL rd_exclusive: got cyc=%b stb=%b vld=%b last=%b", cyc_o, stb_o, m_vld_o, m_last_o);
      end
      if (stb_o) begin
        checks++;
        if (adr_o !== ABITS'(count) || bst_o !== (count != WORDS - 1)) begin
          errors++;
          $display("FAIL rd_addr: got adr=%0d bst=%b expected %0d %b",
                   adr_o, bst_o, count, (count != WORDS - 1));
        end
      end
      m_rdy_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = m_vld_o && !m_rdy_i;
      held_dat = m_dat_o;
      held_last = m_last_o;
      if (m_vld_o && m_rdy_i) begin
        exp_dat = (exp_q.size() > 0) ? exp_q.pop_front() : ~m_dat_o;
        checks++;
        if (m_dat_o !== exp_dat || m_last_o !== (count == WORDS - 1)) begin
          errors++;
          $display("FAIL rd_word %0d: got dat=%0h last=%b expected %0h %b",
                   count, m_dat_o, m_last_o, exp_dat, (count == WORDS - 1));
        end
        count++;
      end
      @(negedge clk_i);
    end
    checks++;
    if (count != WORDS) begin
      errors++;
      $display("FAIL rd_count: got %0d words expected %0d", count, WORDS);
    end
    m_rdy_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (cyc_o !== 1'b0 || m_vld_o !== 1'b0 || exp_q.size() != 0 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: got cyc=%b vld=%b pending=%0d ovr=%b expected 0 0 0 0",
               cyc_o, m_vld_o, exp_q.size(), overrun_o);
    end
  endtask

  task automatic test_overrun();
    int nsw;
    int n;
    do_reset();
    m_rdy_i = 1'b0;
    blocksize_i = 5'd3; enable_i = 1'b1; strobe_i = 1'b1;
    nsw = 0;
    n = 0;
    while (nsw < 2 && n < 60) begin
      @(negedge clk_i);
      n++;
      if (sw_o === 1'b1) nsw++;
    end
    checks++;
    if (nsw != 2) begin
      errors++;
      $display("FAIL ovr_second_switch: got %0d switches expected 2", nsw);
    end
    checks++;
    if (m_vld_o !== 1'b1 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL ovr_before: got vld=%b ovr=%b expected 1 0", m_vld_o, overrun_o);
    end
    enable_i = 1'b0; strobe_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (overrun_o !== 1'b1 || m_vld_o !== 1'b0 || cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL ovr_abort: got ovr=%b vld=%b cyc=%b expected 1 0 0", overrun_o, m_vld_o, cyc_o);
    end
    n = 1;
    while (stb_o !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n != SETTLE + 1 || adr_o !== '0) begin
      errors++;
      $display("FAIL ovr_restart: got stb after %0d adr=%0d expected %0d adr 0", n, adr_o, SETTLE + 1);
    end
    repeat (10) @(negedge clk_i);
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: got %b expected 1", overrun_o);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int n;
    bit bad;
    do_reset();
    fire_switch();
    n = 0;
    while (!(stb_o === 1'b1 && adr_o === ABITS'(50)) && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL mid_reach50: address 50 not seen, got adr=%0d", adr_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sw_o, cyc_o, stb_o, bst_o, m_vld_o, m_last_o, overrun_o} !== 7'h00 ||
        adr_o !== '0 || m_dat_o !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got ctl=%b adr=%0d dat=%0h expected all zero",
               {sw_o, cyc_o, stb_o, bst_o, m_vld_o, m_last_o, overrun_o}, adr_o, m_dat_o);
    end
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (cyc_o !== 1'b0 || m_vld_o !== 1'b0 || sw_o !== 1'b0 || overrun_o !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_idle_after: got activity cyc=%b vld=%b expected idle", cyc_o, m_vld_o);
    end
    exp_q.delete();
    fire_switch();
    n = 0;
    while (stb_o !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n != SETTLE + 1 || adr_o !== '0) begin
      errors++;
      $display("FAIL mid_next_readout: got stb after %0d adr=%0d expected %0d adr 0", n, adr_o, SETTLE + 1);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_block_timer();
    test_readout(1'b0);
    test_readout(1'b1);
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
